// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared state encoding and sizing helper for the sipo_deser slice.
package sipo_pkg;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAR  = 1'b1
  } state_e;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_hold.sv
// rtl/sipo_hold.sv - one-word holding register with valid/ready handshake and sticky overrun.
module sipo_hold #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          overrun,
  input  logic          clr_ovr
);

  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          load;
  logic          ovr_event;

  always_comb begin
    load      = in_valid & (~valid_q | out_ready);
    ovr_event = in_valid & valid_q & ~out_ready;
    data_d    = load ? in_data : data_q;
    valid_d   = valid_q;
    if (load)           valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
    // A fresh overrun outranks a clear landing in the same cycle.
    ovr_d = ovr_q;
    if (ovr_event)    ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in parallel-out deserializer with valid/ready output.
// Define SIPO_DESER_PARITY_EN to add a trailing even-parity bit and the par_err output.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             overrun,
  input  logic             clr_ovr
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic             par_err
`endif
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SIPO_DESER_PARITY_EN
  localparam int HW = WIDTH + 1;
`else
  localparam int HW = WIDTH;
`endif

  state_e           state_q, state_d, state_base;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] sh_q, sh_d, sh_base, sh_shift;
  logic             word_done;
  logic [HW-1:0]    word_data;
  logic [HW-1:0]    hold_data;

  // sync drops any partial word but still lets this cycle's bit start a new one.
  assign state_base = sync ? ST_DATA : state_q;
  assign cnt_base   = sync ? '0 : cnt_q;
  assign sh_base    = sync ? '0 : sh_q;
  assign sh_shift   = MSB_FIRST ? {sh_base[WIDTH-2:0], ser_in}
                                : {ser_in, sh_base[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_DATA;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_base;
`ifdef SIPO_DESER_PARITY_EN
    if (ser_valid) begin
      if (state_base == ST_PAR)  state_d = ST_DATA;
      else if (cnt_base == LAST) state_d = ST_PAR;
    end
`endif
  end

  always_comb begin
    cnt_d     = cnt_base;
    sh_d      = sh_base;
    word_done = 1'b0;
`ifdef SIPO_DESER_PARITY_EN
    word_data = {(^sh_base) ^ ser_in, sh_base};
    if (ser_valid) begin
      if (state_base == ST_PAR) begin
        word_done = 1'b1;
      end else begin
        sh_d  = sh_shift;
        cnt_d = (cnt_base == LAST) ? '0 : cnt_base + 1'b1;
      end
    end
`else
    word_data = sh_shift;
    if (ser_valid) begin
      sh_d = sh_shift;
      if (cnt_base == LAST) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_base + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  sipo_hold #(.DW(HW)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (word_done),
    .in_data   (word_data),
    .out_data  (hold_data),
    .out_valid (par_valid),
    .out_ready (par_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

`ifdef SIPO_DESER_PARITY_EN
  assign {par_err, par_out} = hold_data;
`else
  assign par_out = hold_data;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - directed bench for sipo_deser (WIDTH=4, MSB_FIRST=1).
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in, ser_valid, sync, par_ready, clr_ovr;
  logic [3:0] par_out;
  logic       par_valid, overrun;
`ifdef SIPO_DESER_PARITY_EN
  logic       par_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .sync      (sync),
    .par_out   (par_out),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
`ifdef SIPO_DESER_PARITY_EN
    ,
    .par_err   (par_err)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in    = b;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    rst = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; sync = 1'b0;
    par_ready = 1'b1; clr_ovr = 1'b0;
    tick(); tick();
    check("rst_par_out", 8'(par_out), 8'h0);
    check("rst_par_valid", 8'(par_valid), 8'h0);
    check("rst_overrun", 8'(overrun), 8'h0);
    rst = 1'b1;
    tick();

    // reset mid-word discards the two bits already taken
    send_bit(1'b1); send_bit(1'b1);
    rst = 1'b0; #1; rst = 1'b1;
    tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("reset_no_early", 8'(par_valid), 8'h0);
    send_bit(1'b1);
    check("reset_valid", 8'(par_valid), 8'h1);
    check("reset_word", 8'(par_out), 8'hB);
    tick();
    check("reset_pulse_end", 8'(par_valid), 8'h0);

    // gaps between valid bits
    send_bit(1'b0); tick();
    send_bit(1'b1); tick();
    send_bit(1'b1); tick();
    check("gap_no_early", 8'(par_valid), 8'h0);
    send_bit(1'b0);
    check("gap_valid", 8'(par_valid), 8'h1);
    check("gap_word", 8'(par_out), 8'h6);
    tick();

    // backpressure and overrun
    par_ready = 1'b0;
    send_word(4'hA);
    check("bp_first_valid", 8'(par_valid), 8'h1);
    check("bp_no_ovr_yet", 8'(overrun), 8'h0);
    send_word(4'h5);
    check("bp_held_word", 8'(par_out), 8'hA);
    check("bp_overrun", 8'(overrun), 8'h1);
    check("bp_still_valid", 8'(par_valid), 8'h1);
    par_ready = 1'b1;
    tick();
    check("bp_consumed", 8'(par_valid), 8'h0);
    check("bp_ovr_sticky", 8'(overrun), 8'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("bp_ovr_cleared", 8'(overrun), 8'h0);

    // consume and reload on the same edge
    par_ready = 1'b0;
    send_word(4'h3);
    check("sim_held", 8'(par_out), 8'h3);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    par_ready = 1'b1;
    send_bit(1'b0);
    check("sim_valid", 8'(par_valid), 8'h1);
    check("sim_word", 8'(par_out), 8'hC);
    check("sim_no_ovr", 8'(overrun), 8'h0);

    // overrun wins over a simultaneous clear
    par_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    clr_ovr = 1'b1;
    send_bit(1'b1);
    clr_ovr = 1'b0;
    check("ovr_beats_clr", 8'(overrun), 8'h1);
    check("ovr_kept_word", 8'(par_out), 8'hC);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_clr_alone", 8'(overrun), 8'h0);
    par_ready = 1'b1;
    tick();
    check("drain", 8'(par_valid), 8'h0);

    // resync with a bit on the sync cycle
    send_bit(1'b1); send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b1);
    sync = 1'b0;
    send_bit(1'b0); send_bit(1'b0);
    check("sync_no_early", 8'(par_valid), 8'h0);
    send_bit(1'b1);
    check("sync_valid", 8'(par_valid), 8'h1);
    check("sync_word", 8'(par_out), 8'h9);
    tick();

`ifdef SIPO_DESER_PARITY_EN
    send_word(4'hB);
    check("par_wait_bit", 8'(par_valid), 8'h0);
    send_bit(1'b1);
    check("par_ok_word", 8'(par_out), 8'hB);
    check("par_ok_err", 8'(par_err), 8'h0);
    tick();
    send_word(4'hB);
    send_bit(1'b0);
    check("par_bad_word", 8'(par_out), 8'hB);
    check("par_bad_err", 8'(par_err), 8'h1);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
